// File: rtl/lsu_mem_align_pkg.sv
// ---------------------------------------------------------------------------
// lsu_pkg: shared types and helpers for the load/store alignment unit.
//   state_e      - controller state (IDLE, RMW_WR)
//   SZ_*         - funct3[1:0] access size encodings
//   byte_mask    - 8-bit byte strobe for an access of a given size and offset
//   load_extend  - sign/zero-extends a right-justified lane to 64 bits
// ---------------------------------------------------------------------------
package lsu_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    RMW_WR = 1'b1
  } state_e;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;

  function automatic logic [7:0] byte_mask(input logic [1:0] size, input logic [2:0] off);
    logic [7:0] m;
    case (size)
      SZ_B:    m = 8'h01;
      SZ_H:    m = 8'h03;
      SZ_W:    m = 8'h0F;
      default: m = 8'hFF;
    endcase
    return m << off;
  endfunction

  function automatic logic [63:0] load_extend(input logic [63:0] data, input logic [1:0] size,
                                              input logic is_unsigned);
    logic [63:0] r;
    case (size)
      SZ_B:    r = is_unsigned ? {56'd0, data[7:0]}  : {{56{data[7]}},  data[7:0]};
      SZ_H:    r = is_unsigned ? {48'd0, data[15:0]} : {{48{data[15]}}, data[15:0]};
      SZ_W:    r = is_unsigned ? {32'd0, data[31:0]} : {{32{data[31]}}, data[31:0]};
      default: r = data;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/lsu_mem_align_lane_merge.sv
// ---------------------------------------------------------------------------
// lsu_lane_merge: combinational byte-lane merge for sub-doubleword stores.
//   old_data_i  64  current memory entry
//   new_data_i  64  right-justified store data
//   size_i       2  access size (funct3[1:0])
//   off_i        3  byte offset within the entry
//   merged_o    64  old entry with bytes [off, off+nbytes) replaced
// ---------------------------------------------------------------------------
module lsu_lane_merge
  import lsu_pkg::*;
(
  input  logic [63:0] old_data_i,
  input  logic [63:0] new_data_i,
  input  logic [1:0]  size_i,
  input  logic [2:0]  off_i,
  output logic [63:0] merged_o
);

  logic [63:0] shifted;
  logic [7:0]  mask;

  assign shifted = new_data_i << {off_i, 3'b000};
  assign mask    = byte_mask(size_i, off_i);

  always_comb begin
    for (int i = 0; i < 8; i++) begin
      merged_o[8*i +: 8] = mask[i] ? shifted[8*i +: 8] : old_data_i[8*i +: 8];
    end
  end

endmodule

// File: rtl/lsu_mem_align.sv
// ---------------------------------------------------------------------------
// lsu_mem_align: turns RISC-V B/H/W/D loads and stores into whole 64-bit
// entry accesses on the data memory.
//   clk, rst_n                 clock, async active-low reset
//   req_valid/req_ready        request handshake (ready only in IDLE)
//   req_we, req_funct3         store flag, size [1:0] and unsigned [2]
//   req_addr, req_wdata        byte address, right-justified store data
//   resp_valid/rdata/err       one-cycle response pulse, extended load data
//   mem_addr/din/read/write    entry-aligned memory interface
//   mem_dout                   combinational memory read data
// Loads and doubleword stores complete in one cycle; narrower stores read
// the entry in the accept cycle and write the merged entry in RMW_WR.
// ---------------------------------------------------------------------------
module lsu_mem_align
  import lsu_pkg::*;
#(
  parameter int DMEM_ADDR_WIDTH = 10
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic                       req_we,
  input  logic [2:0]                 req_funct3,
  input  logic [63:0]                req_addr,
  input  logic [63:0]                req_wdata,
  output logic                       resp_valid,
  output logic [63:0]                resp_rdata,
  output logic                       resp_err,
  output logic [DMEM_ADDR_WIDTH-1:0] mem_addr,
  output logic [63:0]                mem_din,
  output logic                       mem_read,
  output logic                       mem_write,
  input  logic [63:0]                mem_dout
);

  state_e                     state_q, state_d;
  logic                       resp_valid_q, resp_valid_d;
  logic                       resp_err_q, resp_err_d;
  logic [63:0]                resp_rdata_q, resp_rdata_d;
  logic [63:0]                merge_q, merge_d;
  logic [DMEM_ADDR_WIDTH-1:0] addr_q, addr_d;

  logic [1:0]                 size;
  logic [2:0]                 off;
  logic [DMEM_ADDR_WIDTH-1:0] req_addr_aligned;
  logic                       misaligned, illegal, accept;
  logic [63:0]                merged, lane;

  assign size             = req_funct3[1:0];
  assign off              = req_addr[2:0];
  assign req_addr_aligned = {req_addr[DMEM_ADDR_WIDTH-1:3], 3'b000};
  // Offset must be a multiple of the access size: the low log2(nbytes) bits
  // of the offset have to be zero.
  assign misaligned       = (off & 3'((4'd1 << size) - 4'd1)) != 3'd0;
  assign illegal          = (req_we && req_funct3[2]) || (req_funct3 == 3'b111);
  assign accept           = req_valid && (state_q == IDLE);
  assign lane             = mem_dout >> {off, 3'b000};

  lsu_lane_merge u_merge (
    .old_data_i (mem_dout),
    .new_data_i (req_wdata),
    .size_i     (size),
    .off_i      (off),
    .merged_o   (merged)
  );

  always_comb begin
    // NOTE: every signal assigned here gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    state_d      = state_q;
    resp_valid_d = 1'b0;
    resp_err_d   = 1'b0;
    resp_rdata_d = resp_rdata_q;
    merge_d      = merge_q;
    addr_d       = addr_q;
    req_ready    = 1'b0;
    mem_addr     = req_addr_aligned;
    mem_din      = '0;
    mem_read     = 1'b0;
    mem_write    = 1'b0;

    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (accept) begin
          if (misaligned || illegal) begin
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
            resp_rdata_d = '0;
          end else if (!req_we) begin
            mem_read     = 1'b1;
            resp_valid_d = 1'b1;
            resp_rdata_d = load_extend(lane, size, req_funct3[2]);
          end else if (size == SZ_D) begin
            mem_write    = 1'b1;
            mem_din      = req_wdata;
            resp_valid_d = 1'b1;
            resp_rdata_d = '0;
          end else begin
            mem_read = 1'b1;
            merge_d  = merged;
            addr_d   = req_addr_aligned;
            state_d  = RMW_WR;
          end
        end
      end
      RMW_WR: begin
        mem_write    = 1'b1;
        mem_din      = merge_q;
        mem_addr     = addr_q;
        resp_valid_d = 1'b1;
        resp_rdata_d = '0;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples pre-edge values, independent of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
      merge_q      <= '0;
      addr_q       <= '0;
    end else begin
      state_q      <= state_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
      merge_q      <= merge_d;
      addr_q       <= addr_d;
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign resp_rdata = resp_rdata_q;

endmodule

// File: tb/tb_lsu_mem_align.sv
// ---------------------------------------------------------------------------
// tb_lsu_mem_align: directed self-checking bench for lsu_mem_align with a
// small 64-bit-entry memory model (combinational read, write on rising edge).
// ---------------------------------------------------------------------------
module tb_lsu_mem_align;

  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid, req_ready, req_we;
  logic [2:0]    req_funct3;
  logic [63:0]   req_addr, req_wdata;
  logic          resp_valid, resp_err;
  logic [63:0]   resp_rdata;
  logic [AW-1:0] mem_addr;
  logic [63:0]   mem_din, mem_dout;
  logic          mem_read, mem_write;

  logic [63:0]   mem [128];

  int n_checks = 0;
  int n_pass   = 0;

  // Results of the most recent issue() call.
  logic          acc_rd, acc_wr, acc_ready;
  logic [63:0]   acc_din;
  logic          rmw_wr, rmw_ready;
  logic [63:0]   rmw_din;
  logic [63:0]   r_data;
  logic          r_err;
  int            r_lat;

  always #5 clk = ~clk;

  assign mem_dout = mem[mem_addr[AW-1:3]];
  always @(posedge clk) if (mem_write) mem[mem_addr[AW-1:3]] <= mem_din;

  lsu_mem_align #(.DMEM_ADDR_WIDTH(AW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_addr   (mem_addr),
    .mem_din    (mem_din),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_dout   (mem_dout)
  );

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, act, exp);
  endtask

  // Called 1 time unit after a rising edge with req_ready high. Samples the
  // accept-cycle memory controls, then waits (bounded) for resp_valid.
  task automatic issue(input logic we, input logic [2:0] f3, input logic [63:0] addr,
                       input logic [63:0] wd);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wd;
    #3;
    acc_rd    = mem_read;
    acc_wr    = mem_write;
    acc_din   = mem_din;
    acc_ready = req_ready;
    @(posedge clk); #1;
    req_valid = 1'b0;
    rmw_wr    = 1'b0;
    rmw_ready = 1'b1;
    rmw_din   = '0;
    r_lat     = 1;
    while (!resp_valid && r_lat < 5) begin
      if (r_lat == 1) begin
        rmw_wr    = mem_write;
        rmw_ready = req_ready;
        rmw_din   = mem_din;
      end
      @(posedge clk); #1;
      r_lat++;
    end
    r_data = resp_rdata;
    r_err  = resp_err;
  endtask

  task automatic check_load(input string tag, input logic [2:0] f3, input logic [63:0] addr,
                            input logic [63:0] exp);
    issue(1'b0, f3, addr, 64'd0);
    check({tag, "_lat"}, 64'(r_lat), 64'd1);
    check({tag, "_rd"}, 64'(acc_rd), 64'd1);
    check({tag, "_data"}, r_data, exp);
    check({tag, "_err"}, 64'(r_err), 64'd0);
  endtask

  task automatic check_err(input string tag, input logic we, input logic [2:0] f3,
                           input logic [63:0] addr);
    issue(we, f3, addr, 64'hFFFF_FFFF_FFFF_FFFF);
    check({tag, "_lat"}, 64'(r_lat), 64'd1);
    check({tag, "_err"}, 64'(r_err), 64'd1);
    check({tag, "_data"}, r_data, 64'd0);
    check({tag, "_memctl"}, {62'd0, acc_rd, acc_wr}, 64'd0);
  endtask

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = 64'd0;
    mem[0]     = 64'h8877_6655_4433_2211;
    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_funct3 = 3'd0;
    req_addr   = '0;
    req_wdata  = '0;
    #12;
    check("rst_ready", 64'(req_ready), 64'd1);
    check("rst_resp_valid", 64'(resp_valid), 64'd0);
    check("rst_rdata", resp_rdata, 64'd0);
    check("rst_memctl", {62'd0, mem_read, mem_write}, 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Loads from entry 0.
    check_load("lb7",  3'b000, 64'd7, 64'hFFFF_FFFF_FFFF_FF88);
    check_load("lbu7", 3'b100, 64'd7, 64'h0000_0000_0000_0088);
    check_load("lhu6", 3'b101, 64'd6, 64'h0000_0000_0000_8877);
    check_load("lw4",  3'b010, 64'd4, 64'hFFFF_FFFF_8877_6655);
    check_load("lh0",  3'b001, 64'd0, 64'h0000_0000_0000_2211);

    // Byte store via read-modify-write.
    issue(1'b1, 3'b000, 64'd3, 64'h0000_0000_0000_00AB);
    check("sb3_acc_wr", 64'(acc_wr), 64'd0);
    check("sb3_acc_rd", 64'(acc_rd), 64'd1);
    check("sb3_rmw_ready", 64'(rmw_ready), 64'd0);
    check("sb3_rmw_wr", 64'(rmw_wr), 64'd1);
    check("sb3_rmw_din", rmw_din, 64'h8877_6655_AB33_2211);
    check("sb3_lat", 64'(r_lat), 64'd2);
    check("sb3_err", 64'(r_err), 64'd0);
    check_load("ld0_after_sb", 3'b011, 64'd0, 64'h8877_6655_AB33_2211);

    // Word store into the upper half of entry 0.
    issue(1'b1, 3'b010, 64'd4, 64'h1234_5678_CAFE_F00D);
    check("sw4_rmw_din", rmw_din, 64'hCAFE_F00D_AB33_2211);
    check("sw4_lat", 64'(r_lat), 64'd2);
    check_load("lwu4", 3'b110, 64'd4, 64'h0000_0000_CAFE_F00D);

    // Doubleword store writes directly.
    issue(1'b1, 3'b011, 64'd8, 64'hDEAD_BEEF_0123_4567);
    check("sd8_acc_wr", 64'(acc_wr), 64'd1);
    check("sd8_acc_rd", 64'(acc_rd), 64'd0);
    check("sd8_acc_din", acc_din, 64'hDEAD_BEEF_0123_4567);
    check("sd8_lat", 64'(r_lat), 64'd1);
    check_load("ld8", 3'b011, 64'd8, 64'hDEAD_BEEF_0123_4567);

    // Error cases.
    check_err("lw2_mis", 1'b0, 3'b010, 64'd2);
    check_err("sh5_mis", 1'b1, 3'b001, 64'd5);
    check_err("sb_uns", 1'b1, 3'b100, 64'd0);
    check_err("l111", 1'b0, 3'b111, 64'd0);
    check_load("ld0_after_err", 3'b011, 64'd0, 64'hCAFE_F00D_AB33_2211);

    // Reset during RMW_WR abandons the store.
    req_valid  = 1'b1;
    req_we     = 1'b1;
    req_funct3 = 3'b001;
    req_addr   = 64'd2;
    req_wdata  = 64'h0000_0000_0000_5A5A;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("abort_in_rmw", 64'(req_ready), 64'd0);
    rst_n = 1'b0;
    #1;
    check("abort_no_write", 64'(mem_write), 64'd0);
    check("abort_no_resp", 64'(resp_valid), 64'd0);
    @(posedge clk); #1;
    check("abort_no_resp2", 64'(resp_valid), 64'd0);
    rst_n = 1'b1;
    check("abort_ready", 64'(req_ready), 64'd1);
    @(posedge clk); #1;
    check_load("ld0_after_abort", 3'b011, 64'd0, 64'hCAFE_F00D_AB33_2211);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
